// File: rtl/i2c_byte_master_if.sv
// Signal bundle between the byte sequencer, its host, the SCL generator and the I2C pads.
interface i2c_byte_master_if;
    logic        start;
    logic        rw;
    logic [6:0]  dev_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        ack_err;
    logic [7:0]  rd_data;
    logic        gen_run;
    logic        gen_idle;
    logic [15:0] limit;
    logic        scl_in;
    logic        half_t;
    logic        sda_in;
    logic        sda_oe;
    logic        scl_oe;

    modport master (
        input  start, rw, dev_addr, wr_data, scl_in, half_t, sda_in,
        output busy, done, ack_err, rd_data, gen_run, gen_idle, limit, sda_oe, scl_oe
    );

    modport slave (
        output start, rw, dev_addr, wr_data, scl_in, half_t, sda_in,
        input  busy, done, ack_err, rd_data, gen_run, gen_idle, limit, sda_oe, scl_oe
    );
endinterface

// File: rtl/i2c_byte_master.sv
// One-shot I2C transaction sequencer: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Paced by the SCL generator's half_t marker; SDA moves mid-low, is sampled mid-high.
module i2c_byte_master #(
    parameter logic [15:0] DIV = 16'd250
) (
    input  logic               clk,
    input  logic               rst_n,
    i2c_byte_master_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK,
        S_RD, S_RD_NACK, S_STOP, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        rw_q, rw_d;
    logic [7:0]  wr_q, wr_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        half_q;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ack_err_q, ack_err_d;
    logic [7:0]  rd_q, rd_d;
    logic        gen_run_q, gen_run_d;
    logic        sda_oe_q, sda_oe_d;

    logic mid, mid_hi, mid_lo;

    // A held-high half_t must yield a single event, hence the edge detect.
    assign mid    = bus.half_t & ~half_q;
    assign mid_hi = mid & bus.scl_in;
    assign mid_lo = mid & ~bus.scl_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rw_q      <= 1'b0;
            wr_q      <= 8'h00;
            shift_q   <= 8'h00;
            cnt_q     <= 3'd0;
            half_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rd_q      <= 8'h00;
            gen_run_q <= 1'b0;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            wr_q      <= wr_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            half_q    <= bus.half_t;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            rd_q      <= rd_d;
            gen_run_q <= gen_run_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        wr_d      = wr_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        rd_d      = rd_q;
        gen_run_d = gen_run_q;
        sda_oe_d  = sda_oe_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rw_d      = bus.rw;
                    wr_d      = bus.wr_data;
                    shift_d   = {bus.dev_addr, bus.rw};
                    gen_run_d = 1'b1;
                    busy_d    = 1'b1;
                    ack_err_d = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (mid_hi) begin
                    sda_oe_d = 1'b1;
                    cnt_d    = 3'd7;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR, S_WR: begin
                if (mid_lo) begin
                    sda_oe_d = ~shift_q[7];
                    shift_d  = {shift_q[6:0], 1'b0};
                end else if (mid_hi) begin
                    if (cnt_q == 3'd0) begin
                        state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            S_ADDR_ACK: begin
                if (mid_lo) begin
                    sda_oe_d = 1'b0;
                end else if (mid_hi) begin
                    if (bus.sda_in) begin
                        ack_err_d = 1'b1;
                        state_d   = S_STOP;
                    end else if (!rw_q) begin
                        shift_d = wr_q;
                        cnt_d   = 3'd7;
                        state_d = S_WR;
                    end else begin
                        cnt_d   = 3'd7;
                        state_d = S_RD;
                    end
                end
            end
            S_WR_ACK: begin
                if (mid_lo) begin
                    sda_oe_d = 1'b0;
                end else if (mid_hi) begin
                    if (bus.sda_in) begin
                        ack_err_d = 1'b1;
                    end
                    state_d = S_STOP;
                end
            end
            S_RD: begin
                if (mid_lo) begin
                    sda_oe_d = 1'b0;
                end else if (mid_hi) begin
                    rd_d = {rd_q[6:0], bus.sda_in};
                    if (cnt_q == 3'd0) begin
                        state_d = S_RD_NACK;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            S_RD_NACK: begin
                if (mid_lo) begin
                    sda_oe_d = 1'b0;
                end else if (mid_hi) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // SDA must be held low through a low phase before it may rise as STOP.
                if (mid_lo) begin
                    sda_oe_d = 1'b1;
                end else if (mid_hi && sda_oe_q) begin
                    sda_oe_d  = 1'b0;
                    gen_run_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ack_err  = ack_err_q;
    assign bus.rd_data  = rd_q;
    assign bus.gen_run  = gen_run_q;
    assign bus.gen_idle = 1'b1;
    assign bus.limit    = DIV;
    assign bus.sda_oe   = sda_oe_q;
    assign bus.scl_oe   = gen_run_q & ~bus.scl_in;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: SCL generator model, behavioural I2C slave and bus monitor.
module tb_i2c_byte_master;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    i2c_byte_master_if bus();

    i2c_byte_master #(.DIV(16'(DIV))) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // SCL generator: idles high, toggles every DIV clocks, half_t pulse mid-phase
    int   gcnt = 0;
    logic stretch = 1'b0;
    always @(posedge clk) begin
        if (!bus.gen_run) begin
            gcnt       <= 0;
            bus.scl_in <= 1'b1;
            bus.half_t <= 1'b0;
        end else begin
            if (gcnt == DIV - 1) begin
                gcnt       <= 0;
                bus.scl_in <= ~bus.scl_in;
            end else begin
                gcnt <= gcnt + 1;
            end
            bus.half_t <= stretch ? (gcnt <= 2) : (gcnt == DIV / 2 - 1);
        end
    end

    // Slave and bus monitor, working only from the pad levels
    logic        slave_low = 1'b0;
    logic [7:0]  s_byte = 8'h00;
    logic        s_ack_a = 1'b1, s_ack_d = 1'b1, s_rw_seen = 1'b0;
    logic        scl_prev = 1'b1, sda_prev = 1'b1;
    int          starts = 0, stops = 0, nbits = 0, done_cnt = 0;
    logic [31:0] stream = 32'h0;

    assign bus.sda_in = ~bus.sda_oe & ~slave_low;

    always @(negedge clk) begin : mon
        logic scl_p, sda_p;
        scl_p = ~bus.scl_oe;
        sda_p = ~bus.sda_oe & ~slave_low;
        if (bus.done === 1'b1) done_cnt++;
        if (scl_p && scl_prev && sda_p != sda_prev) begin
            if (!sda_p) begin
                starts++;
                nbits     = 0;
                stream    = 32'h0;
                slave_low = 1'b0;
            end else begin
                stops++;
            end
        end
        if (scl_p && !scl_prev) begin
            stream = {stream[30:0], sda_p};
            nbits++;
        end
        if (!scl_p && scl_prev) begin
            if (nbits == 8) begin
                s_rw_seen = stream[0];
                slave_low = s_ack_a;
            end else if (nbits >= 9 && nbits <= 16) begin
                slave_low = (s_rw_seen && s_ack_a) ? ~s_byte[3'(16 - nbits)] : 1'b0;
            end else if (nbits == 17) begin
                slave_low = !s_rw_seen && s_ack_a && s_ack_d;
            end else begin
                slave_low = 1'b0;
            end
        end
        scl_prev = scl_p;
        sda_prev = ~bus.sda_oe & ~slave_low;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: bits seen on SDA at each SCL rise, final status and read byte
    function automatic void ref_model(input logic [6:0] a, input logic r, input logic [7:0] w,
                                      input logic [7:0] sb, input logic aa, input logic ad,
                                      input logic [7:0] rd_prev, output logic [31:0] st,
                                      output int n, output logic err, output logic [7:0] rd);
        bit q[$];
        for (int i = 6; i >= 0; i--) q.push_back(a[i]);
        q.push_back(r);
        q.push_back(!aa);
        if (aa) begin
            for (int i = 7; i >= 0; i--) q.push_back(r ? sb[i] : w[i]);
            q.push_back(r ? 1'b1 : !ad);
        end
        q.push_back(1'b0);  // clock carrying the STOP setup, SDA held low
        st = 32'h0;
        foreach (q[k]) st = {st[30:0], q[k]};
        n   = q.size();
        err = !aa || (!r && !ad);
        rd  = (r && aa) ? sb : rd_prev;
    endfunction

    task automatic pulse_start(input logic [6:0] a, input logic r, input logic [7:0] w);
        @(negedge clk);
        bus.start = 1'b1; bus.dev_addr = a; bus.rw = r; bus.wr_data = w;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        i = 0;
        while (bus.done !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done not seen after %0d cycles, required within %0d", name, i, budget);
        end
    endtask

    task automatic do_txn(input string tag, input logic [6:0] a, input logic r, input logic [7:0] w,
                          input logic [7:0] sb, input logic aa, input logic ad,
                          input logic exp_err, input logic [7:0] exp_rd);
        logic [31:0] est;
        int          en;
        logic        eerr;
        logic [7:0]  erd;
        ref_model(a, r, w, sb, aa, ad, 8'h00, est, en, eerr, erd);
        s_byte = sb; s_ack_a = aa; s_ack_d = ad;
        starts = 0; stops = 0; done_cnt = 0;
        pulse_start(a, r, w);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(tag, 3000);
        repeat (3) @(negedge clk);
        chk({tag, "_ack_err"}, 32'(bus.ack_err), 32'(exp_err));
        chk({tag, "_rd_data"}, 32'(bus.rd_data), 32'(exp_rd));
        chk({tag, "_nbits"}, 32'(nbits), 32'(en));
        chk({tag, "_stream"}, stream, est);
        chk({tag, "_starts"}, 32'(starts), 32'd1);
        chk({tag, "_stops"}, 32'(stops), 32'd1);
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        chk({tag, "_gen_run_after"}, 32'(bus.gen_run), 32'd0);
    endtask

    typedef struct {
        logic [6:0] a;
        logic       r;
        logic [7:0] w;
        logic [7:0] sb;
        logic       aa;
        logic       ad;
        logic       exp_err;
        logic [7:0] exp_rd;
    } vec_t;

    initial begin : wdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t        tbl[6];
        logic [7:0]  rd_model;
        logic [31:0] est;
        int          en, i;
        logic        eerr;
        logic [7:0]  erd;

        tbl[0] = '{7'h50, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[1] = '{7'h3C, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A};
        tbl[2] = '{7'h22, 1'b0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A};
        tbl[3] = '{7'h7F, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A};
        tbl[4] = '{7'h01, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b1, 1'b1, 8'h5A};
        tbl[5] = '{7'h15, 1'b1, 8'h00, 8'h81, 1'b1, 1'b1, 1'b0, 8'h81};

        bus.start = 1'b0; bus.rw = 1'b0; bus.dev_addr = 7'h00; bus.wr_data = 8'h00;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ack_err", 32'(bus.ack_err), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_gen_run", 32'(bus.gen_run), 32'd0);
        chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("rst_scl_oe", 32'(bus.scl_oe), 32'd0);
        chk("rst_gen_idle", 32'(bus.gen_idle), 32'd1);
        chk("rst_limit", 32'(bus.limit), 32'(DIV));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 6; k++)
            do_txn($sformatf("vec%0d", k), tbl[k].a, tbl[k].r, tbl[k].w, tbl[k].sb,
                   tbl[k].aa, tbl[k].ad, tbl[k].exp_err, tbl[k].exp_rd);
        rd_model = tbl[5].exp_rd;

        for (int k = 0; k < 12; k++) begin
            logic [6:0] a;
            logic       r, aa, ad;
            logic [7:0] w, sb;
            a  = 7'($urandom);
            r  = 1'($urandom);
            w  = 8'($urandom);
            sb = 8'($urandom);
            aa = ($urandom_range(0, 3) != 0);
            ad = ($urandom_range(0, 3) != 0);
            ref_model(a, r, w, sb, aa, ad, rd_model, est, en, eerr, erd);
            do_txn($sformatf("rnd%0d", k), a, r, w, sb, aa, ad, eerr, erd);
            rd_model = erd;
        end

        // Repeated start while busy: only the first is taken (address NACK leaves ack_err set)
        s_ack_a = 1'b0; s_ack_d = 1'b1;
        starts = 0; stops = 0; done_cnt = 0;
        pulse_start(7'h10, 1'b0, 8'h33);
        repeat (10) @(negedge clk);
        pulse_start(7'h55, 1'b1, 8'h44);
        repeat (30) @(negedge clk);
        pulse_start(7'h66, 1'b0, 8'h99);
        wait_done("multi", 3000);
        repeat (3) @(negedge clk);
        chk("multi_done_pulses", 32'(done_cnt), 32'd1);
        chk("multi_ack_err", 32'(bus.ack_err), 32'd1);
        chk("multi_nbits", 32'(nbits), 32'd10);
        repeat (40) @(negedge clk);
        chk("multi_no_requeue", 32'(done_cnt), 32'd1);
        chk("multi_idle_busy", 32'(bus.busy), 32'd0);

        // Next start is accepted and clears ack_err; start during the done cycle is dropped
        s_ack_a = 1'b1; s_ack_d = 1'b1;
        done_cnt = 0;
        pulse_start(7'h50, 1'b0, 8'h5C);
        chk("restart_ack_err_clear", 32'(bus.ack_err), 32'd0);
        chk("restart_busy", 32'(bus.busy), 32'd1);
        wait_done("restart", 3000);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("start_in_done_ignored", 32'(bus.busy), 32'd0);
        chk("start_in_done_gen_run", 32'(bus.gen_run), 32'd0);
        chk("restart_done_pulses", 32'(done_cnt), 32'd1);

        // half_t held high for most of each phase must still count once per phase
        stretch = 1'b1;
        do_txn("stretch_wr", 7'h2A, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, rd_model);
        do_txn("stretch_rd", 7'h3C, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h5A);
        stretch = 1'b0;

        // Reset during data bit 4 of a write, with both lines pulled low
        s_ack_a = 1'b1; s_ack_d = 1'b1;
        done_cnt = 0;
        pulse_start(7'h50, 1'b0, 8'hA5);
        i = 0;
        while (!(nbits == 13 && bus.scl_oe === 1'b1 && bus.sda_oe === 1'b1) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        chk("midrst_reached_bit4", 32'(nbits == 13 && bus.sda_oe === 1'b1), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("midrst_scl_oe", 32'(bus.scl_oe), 32'd0);
        chk("midrst_gen_run", 32'(bus.gen_run), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", 32'(done_cnt), 32'd0);
        chk("midrst_idle", 32'(bus.busy), 32'd0);

        do_txn("post_rst", 7'h3C, 1'b1, 8'h00, 8'h96, 1'b1, 1'b1, 1'b0, 8'h96);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
